// File: rtl/cpu6_pipeline_ctrl.sv
// Stall/flush sequencing for the cpu6 IF/ID and ID/EX pipeline registers:
// redirect flushes, load-use bubbles, full drains, and a stall-cycle counter.
//
// state   | meaning
// RUN     | normal issue; redirect / load-use / drain request decoded here
// DRAIN   | ID held, EX fed bubbles while M and W empty out (dcnt counts down)
// RELEASE | single cycle: held ID instruction enters EX, drain_done pulses
module cpu6_pipeline_ctrl #(
  parameter int DRAIN_DEPTH = 2,
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic              use_rs1D,
  input  logic              use_rs2D,
  input  logic              memtoregE,
  input  logic              regwriteE,
  input  logic [REG_AW-1:0] rdE,
  input  logic              redirectE,
  input  logic              empty_pipeline_reqE,
  input  logic              stall_cnt_clr,
  output logic              stallF,
  output logic              stallD,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              drain_active,
  output logic              drain_done,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [3:0] DCNT_INIT = 4'(DRAIN_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] state, state_nxt;
  logic [3:0] dcnt, dcnt_nxt;
  logic       lu;

  assign lu = memtoregE & regwriteE & (rdE != '0) &
              ((use_rs1D & (rs1D == rdE)) | (use_rs2D & (rs2D == rdE)));

  always_comb begin
    stallF       = 1'b0;
    stallD       = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    drain_active = 1'b0;
    drain_done   = 1'b0;
    state_nxt    = state;
    dcnt_nxt     = dcnt;
    if (!reset) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      state_nxt  = ST_RUN;
      dcnt_nxt   = 4'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (empty_pipeline_reqE) begin
            // a same-cycle redirect still squashes the wrong-path fetch
            stallF     = 1'b1;
            stallD     = 1'b1;
            flush_idex = 1'b1;
            flush_ifid = redirectE;
            state_nxt  = ST_DRAIN;
            dcnt_nxt   = DCNT_INIT;
          end else if (redirectE) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (lu) begin
            stallF     = 1'b1;
            stallD     = 1'b1;
            flush_idex = 1'b1;
          end
        end
        ST_DRAIN: begin
          stallF       = 1'b1;
          stallD       = 1'b1;
          flush_idex   = 1'b1;
          drain_active = 1'b1;
          if (dcnt == 4'd0) state_nxt = ST_RELEASE;
          else              dcnt_nxt  = dcnt - 4'd1;
        end
        ST_RELEASE: begin
          drain_done = 1'b1;
          state_nxt  = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state <= state_nxt;
    dcnt  <= dcnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset || stall_cnt_clr) stall_cnt <= '0;
    else if (stallD && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_cpu6_pipeline_ctrl.sv
// Bench for cpu6_pipeline_ctrl: vector table, hand-written drain/reset/saturation
// sequences, then random stimulus against a cycle-level reference model.
module tb_cpu6_pipeline_ctrl;

  localparam int DD = 2;

  logic clk;
  logic reset;
  logic [4:0] rs1D, rs2D, rdE;
  logic use_rs1D, use_rs2D, memtoregE, regwriteE, redirectE, epr, clr;

  logic a_sF, a_sD, a_fi, a_fx, a_da, a_dd;
  logic [15:0] a_cnt;
  logic b_sF, b_sD, b_fi, b_fx, b_da, b_dd;
  logic [3:0] b_cnt;

  cpu6_pipeline_ctrl #(.DRAIN_DEPTH(DD), .REG_AW(5), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D),
    .use_rs2D(use_rs2D), .memtoregE(memtoregE), .regwriteE(regwriteE), .rdE(rdE),
    .redirectE(redirectE), .empty_pipeline_reqE(epr), .stall_cnt_clr(clr),
    .stallF(a_sF), .stallD(a_sD), .flush_ifid(a_fi), .flush_idex(a_fx),
    .drain_active(a_da), .drain_done(a_dd), .stall_cnt(a_cnt));

  cpu6_pipeline_ctrl #(.DRAIN_DEPTH(DD), .REG_AW(5), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D),
    .use_rs2D(use_rs2D), .memtoregE(memtoregE), .regwriteE(regwriteE), .rdE(rdE),
    .redirectE(redirectE), .empty_pipeline_reqE(epr), .stall_cnt_clr(clr),
    .stallF(b_sF), .stallD(b_sD), .flush_ifid(b_fi), .flush_idex(b_fx),
    .drain_active(b_da), .drain_done(b_dd), .stall_cnt(b_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining drain cycles, pending release, plain integer counters
  int m_left = 0;
  bit m_rel  = 0;
  int m_cnt16 = 0;
  int m_cnt4  = 0;
  bit e_sF, e_sD, e_fi, e_fx, e_da, e_dd;

  // Snapshots of the last sampled DUT outputs for the hand-written sequences
  bit s_da, s_dd, s_sD, s_fi;
  int s_cnt16, s_cnt4;

  task automatic model_comb();
    bit lu;
    lu = memtoregE && regwriteE && (rdE != 0) &&
         ((use_rs1D && rs1D == rdE) || (use_rs2D && rs2D == rdE));
    {e_sF, e_sD, e_fi, e_fx, e_da, e_dd} = '0;
    if (!reset) begin
      e_fi = 1; e_fx = 1;
    end else if (m_rel) begin
      e_dd = 1;
    end else if (m_left > 0) begin
      e_sF = 1; e_sD = 1; e_fx = 1; e_da = 1;
    end else if (epr) begin
      e_sF = 1; e_sD = 1; e_fx = 1; e_fi = redirectE;
    end else if (redirectE) begin
      e_fi = 1; e_fx = 1;
    end else if (lu) begin
      e_sF = 1; e_sD = 1; e_fx = 1;
    end
  endtask

  task automatic model_seq();
    if (!reset) begin
      m_left = 0; m_rel = 0; m_cnt16 = 0; m_cnt4 = 0;
    end else begin
      if (clr) begin
        m_cnt16 = 0; m_cnt4 = 0;
      end else if (e_sD) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (m_rel) m_rel = 0;
      else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_rel = 1;
      end else if (epr) m_left = DD;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_comb();
    chk("stallF",       32'(a_sF), 32'(e_sF));
    chk("stallD",       32'(a_sD), 32'(e_sD));
    chk("flush_ifid",   32'(a_fi), 32'(e_fi));
    chk("flush_idex",   32'(a_fx), 32'(e_fx));
    chk("drain_active", 32'(a_da), 32'(e_da));
    chk("drain_done",   32'(a_dd), 32'(e_dd));
    chk("stall_cnt",    32'(a_cnt), 32'(m_cnt16));
    chk("stall_cnt_w4", 32'(b_cnt), 32'(m_cnt4));
    chk("stallD_w4",    32'(b_sD), 32'(e_sD));
    s_da = a_da; s_dd = a_dd; s_sD = a_sD; s_fi = a_fi;
    s_cnt16 = int'(a_cnt); s_cnt4 = int'(b_cnt);
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic idle();
    rs1D = 5'd1; rs2D = 5'd2; rdE = 5'd7;
    use_rs1D = 0; use_rs2D = 0; memtoregE = 0; regwriteE = 0;
    redirectE = 0; epr = 0; clr = 0;
  endtask

  task automatic set_lu();
    memtoregE = 1; regwriteE = 1; rdE = 5'd5; rs2D = 5'd5; use_rs2D = 1;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mem, rw, redir;
    logic x_sF, x_fi, x_fx;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic u1, input logic u2, input logic mem, input logic rw,
                              input logic redir, input logic x_sF, input logic x_fi,
                              input logic x_fx);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2; v.mem = mem; v.rw = rw;
    v.redir = redir; v.x_sF = x_sF; v.x_fi = x_fi; v.x_fx = x_fx;
    return v;
  endfunction

  vec_t vecs[9];
  int cnt_before;

  initial begin
    //            rs1 rs2 rd  u1 u2 mem rw redir  sF fi fx
    vecs[0] = mk(3,  4,  9,  1, 1, 1,  1, 0,     0, 0, 0);
    vecs[1] = mk(3,  4,  3,  1, 0, 1,  1, 0,     1, 0, 1);
    vecs[2] = mk(6,  5,  5,  0, 1, 1,  1, 0,     1, 0, 1);
    vecs[3] = mk(0,  0,  0,  1, 1, 1,  1, 0,     0, 0, 0);
    vecs[4] = mk(5,  5,  5,  0, 0, 1,  1, 0,     0, 0, 0);
    vecs[5] = mk(5,  5,  5,  1, 1, 1,  0, 0,     0, 0, 0);
    vecs[6] = mk(5,  2,  5,  1, 0, 0,  1, 0,     0, 0, 0);
    vecs[7] = mk(5,  2,  5,  1, 0, 1,  1, 1,     0, 1, 1);
    vecs[8] = mk(1,  2,  9,  0, 0, 0,  0, 1,     0, 1, 1);

    idle();
    reset = 0;
    @(posedge clk); #1;
    model_seq();

    // Reset with redirect and load-use present
    redirectE = 1; set_lu();
    for (int i = 0; i < 3; i++) cycle();
    chk("reset_flush_ifid", 32'(s_fi), 32'd1);
    chk("reset_stall_cnt", 32'(s_cnt16), 32'd0);
    reset = 1; idle();
    cycle();
    chk("run_after_reset", 32'(s_sD), 32'd0);

    // Vector table, all from RUN
    for (int i = 0; i < 9; i++) begin
      rs1D = vecs[i].rs1; rs2D = vecs[i].rs2; rdE = vecs[i].rd;
      use_rs1D = vecs[i].u1; use_rs2D = vecs[i].u2;
      memtoregE = vecs[i].mem; regwriteE = vecs[i].rw; redirectE = vecs[i].redir;
      @(negedge clk);
      chk($sformatf("vec%0d_stallF", i), 32'(a_sF), 32'(vecs[i].x_sF));
      chk($sformatf("vec%0d_flush_ifid", i), 32'(a_fi), 32'(vecs[i].x_fi));
      chk($sformatf("vec%0d_flush_idex", i), 32'(a_fx), 32'(vecs[i].x_fx));
      @(posedge clk); #1;
      model_comb(); model_seq();
    end

    // Single load-use bubble bumps counter by one
    idle(); cycle();
    cnt_before = s_cnt16;
    set_lu(); cycle();
    idle(); cycle();
    chk("lu_stall_cnt", 32'(s_cnt16), 32'(cnt_before + 1));
    chk("lu_one_bubble", 32'(s_sD), 32'd0);

    // Drain, without then with a same-cycle redirect
    for (int r = 0; r < 2; r++) begin
      idle(); cycle();
      cnt_before = s_cnt16;
      for (int i = 0; i < 5; i++) begin
        idle();
        if (i == 0) begin
          epr = 1; redirectE = logic'(r);
        end else if (i < 3) begin
          redirectE = 1; epr = 1; set_lu();
        end
        cycle();
        chk($sformatf("drain%0d_active_t%0d", r, i), 32'(s_da), 32'(i == 1 || i == 2));
        chk($sformatf("drain%0d_done_t%0d", r, i), 32'(s_dd), 32'(i == 3));
        chk($sformatf("drain%0d_stallD_t%0d", r, i), 32'(s_sD), 32'(i < 3));
        chk($sformatf("drain%0d_flush_ifid_t%0d", r, i), 32'(s_fi), 32'(i == 0 && r == 1));
      end
      chk($sformatf("drain%0d_stall_cnt", r), 32'(s_cnt16), 32'(cnt_before + 3));
    end

    // Reset in the middle of a drain
    idle(); epr = 1; cycle();
    idle(); reset = 0; cycle();
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("rst_mid_drain_done_%0d", i), 32'(s_dd), 32'd0);
      chk($sformatf("rst_mid_drain_active_%0d", i), 32'(s_da), 32'd0);
    end
    chk("rst_mid_drain_cnt", 32'(s_cnt16), 32'd0);

    // Saturation on the 4-bit counter, then clear beats a concurrent stall
    idle(); set_lu();
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_cnt4", 32'(s_cnt4), 32'd15);
    cycle();
    chk("sat_cnt4_hold", 32'(s_cnt4), 32'd15);
    clr = 1; cycle();
    clr = 0; cycle();
    chk("clr_cnt4", 32'(s_cnt4), 32'd0);
    chk("clr_cnt16", 32'(s_cnt16), 32'd0);

    // Random stimulus against the model
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 49) != 0);
      rs1D      = 5'($urandom_range(0, 3));
      rs2D      = 5'($urandom_range(0, 3));
      rdE       = 5'($urandom_range(0, 3));
      use_rs1D  = 1'($urandom_range(0, 1));
      use_rs2D  = 1'($urandom_range(0, 1));
      memtoregE = 1'($urandom_range(0, 1));
      regwriteE = ($urandom_range(0, 3) != 0);
      redirectE = ($urandom_range(0, 5) == 0);
      epr       = ($urandom_range(0, 11) == 0);
      clr       = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
